seq_divider: RTL and testbench

- Sequential unsigned restoring divider. It is the inverse-operation companion to the shift-add multiplier datapath/controller pair.
- Computes one quotient bit per cycle using a shift/trial-subtract/write loop.
- Split into a small FSM controller and a shift/subtract datapath, the same structure as the multiplier.
- Used by the ALU-level integration as the multi-cycle DIV/REM unit.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_controller.sv | 61 ++++++
 rtl/seq_divider.sv | 121 ++++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents: default operand width and the 2-bit controller state encoding.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Controller state encoding, kept as plain 2-bit constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_controller.sv
// FSM decode for the sequential divider (combinational; the state register
// lives in seq_divider next to the datapath).
// Ports:
//   state      current controller state (IDLE/RUN/DONE)
//   go         start request, only honoured in IDLE
//   div_zero   divisor input is zero (meaningful in IDLE only)
//   is_ge      trial subtraction did not borrow this cycle
//   last_iter  iteration counter is at its final value
//   load       latch operands and initialise the iteration
//   shift_sub  perform one shift/trial-subtract step
//   write_q1   quotient bit shifted in this step is 1
//   finish     publish results and pulse done on this edge
//   next_state state for the next cycle
module div_controller (
  input  logic [1:0] state,
  input  logic       go,
  input  logic       div_zero,
  input  logic       is_ge,
  input  logic       last_iter,
  output logic       load,
  output logic       shift_sub,
  output logic       write_q1,
  output logic       finish,
  output logic [1:0] next_state
);
  import div_pkg::*;

  // Next-state and control decode.
  always_comb begin
    load       = 1'b0;
    shift_sub  = 1'b0;
    write_q1   = 1'b0;
    finish     = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (go) begin
          load = 1'b1;
          // A zero divisor skips the loop and reports straight away.
          if (div_zero) begin
            finish     = 1'b1;
            next_state = DONE;
          end else begin
            next_state = RUN;
          end
        end
      end
      RUN: begin
        shift_sub = 1'b1;
        write_q1  = is_ge;
        if (last_iter) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   go          start request, sampled in IDLE
//   dividend    unsigned dividend, captured when go is accepted
//   divisor     unsigned divisor, captured when go is accepted
//   busy        high from the cycle after acceptance through the DONE cycle
//   done        one-cycle pulse, results valid from this cycle on
//   div_by_zero set with done when the captured divisor was zero
//   quotient    result quotient (all ones on divide by zero)
//   remainder   result remainder (dividend on divide by zero)
module seq_divider #(
  parameter int unsigned WIDTH = div_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  import div_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             is_ge;
  logic             last_iter;
  logic             div_zero;
  logic             load;
  logic             shift_sub;
  logic             write_q1;
  logic             finish;

  assign div_zero  = (divisor == '0);
  assign last_iter = (count == CNT_W'(1));

  // Shift/trial-subtract step. shifted/diff carry one extra MSB so a divisor
  // above 2^(WIDTH-1) cannot overflow; the kept remainder is always below the
  // divisor, so only WIDTH bits of it need storing.
  assign shifted = {1'b0, r_reg, q_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, d_reg};
  assign is_ge   = ~diff[WIDTH];
  assign r_next  = write_q1 ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_next  = {q_reg[WIDTH-2:0], write_q1};

  div_controller u_ctrl (
    .state      (state),
    .go         (go),
    .div_zero   (div_zero),
    .is_ge      (is_ge),
    .last_iter  (last_iter),
    .load       (load),
    .shift_sub  (shift_sub),
    .write_q1   (write_q1),
    .finish     (finish),
    .next_state (next_state)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      busy <= (next_state != IDLE);
      done <= finish;
      if (load) begin
        q_reg       <= dividend;
        d_reg       <= divisor;
        r_reg       <= '0;
        count       <= CNT_W'(WIDTH);
        div_by_zero <= div_zero;
      end else if (shift_sub) begin
        q_reg <= q_next;
        r_reg <= r_next;
        count <= count - CNT_W'(1);
      end
      // Results are written on the edge entering DONE so they are visible
      // together with the done pulse.
      if (finish) begin
        if (load) begin
          quotient  <= '1;
          remainder <= dividend;
        end else begin
          quotient  <= q_next;
          remainder <= r_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands,
// checked by a scoreboard against plain-arithmetic division.
module tb_seq_divider;

  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fails  = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned division; acc is the cycle count seen at the accepting edge.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
    exp_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.cyc = acc;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.cyc = acc + int'(WIDTH);
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL spurious_done: done high with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Present go for one cycle in IDLE, then scramble the operand inputs.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    dividend = a;
    divisor  = b;
    go       = 1'b1;
    sbq.push_back(model(a, b, cyc + 1));
    @(posedge clk); #1;
    go       = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Wait (bounded) for done, counting busy cycles from the current one.
  task automatic wait_done(input int exp_busy);
    int nb   = 0;
    bit seen = 1'b0;
    for (int i = 0; i < int'(WIDTH) + 8 && !seen; i++) begin
      if (busy) nb++;
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (exp_busy >= 0) check("busy_cycles", 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          m;
    reset    = 1'b1;
    go       = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);

    issue(32'd100, 32'd7);                 wait_done(int'(WIDTH) + 1);
    issue(32'hFFFF_FFFF, 32'h8000_0001);   wait_done(int'(WIDTH) + 1);
    issue(32'hFFFF_FFFF, 32'd1);           wait_done(int'(WIDTH) + 1);
    issue(32'd5, 32'd9);                   wait_done(int'(WIDTH) + 1);
    issue(32'd81, 32'd9);                  wait_done(int'(WIDTH) + 1);
    issue(32'h1234, 32'd0);                wait_done(1);
    issue(32'd0, 32'd5);                   wait_done(int'(WIDTH) + 1);

    // go and operand changes while busy must not disturb the running divide.
    issue(32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    go = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    repeat (3) begin @(posedge clk); #1; end
    dividend = $urandom; divisor = 32'd0;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done(-1);

    // Reset mid-run aborts without a done pulse.
    issue(32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    repeat (40) begin @(posedge clk); #1; end
    issue(32'd50, 32'd6);                  wait_done(int'(WIDTH) + 1);

    // Random operands with a mix of divisor shapes.
    for (int k = 0; k < 40; k++) begin
      m = $urandom_range(0, 4);
      a = $urandom;
      case (m)
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd0;
        3:       b = $urandom | 32'h8000_0000;
        default: begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
      endcase
      issue(a, b);
      wait_done((b == 32'd0) ? 1 : int'(WIDTH) + 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
